// File: rtl/mem_arbiter.sv
// Arbitrates one single-port RAM between the icache and dcache. The dcache has fixed priority.
// Define ARB_STARVE_GUARD_EN to bound instruction starvation with STARVE_LIMIT.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, IBUS, DBUS} state_t;

    state_t r_state;
    logic   w_dreq;
    logic   w_access;
    logic   w_force_i;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be in 1..255");
    end

    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == RAM_ACCESS);

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;

    assign w_force_i = iREN && (r_starve_cnt == LIMIT);

    // Counts cycles an instruction fetch waits outside IBUS; held while IBUS is stalled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_starve_cnt <= 8'd0;
        end else if (!iREN) begin
            r_starve_cnt <= 8'd0;
        end else if (r_state == IBUS && w_access) begin
            r_starve_cnt <= 8'd0;
        end else if (r_state != IBUS && r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end
`else
    assign w_force_i = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_force_i)   r_state <= IBUS;
                    else if (w_dreq) r_state <= DBUS;
                    else if (iREN)   r_state <= IBUS;
                end
                DBUS: begin
                    // Dropping the request abandons the grant without a completion.
                    if (!w_dreq || w_access) r_state <= IDLE;
                end
                IBUS: begin
                    if (!iREN || w_access) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM side and waits follow the live request so completion is same-cycle as ACCESS.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (r_state)
            DBUS: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~(w_dreq & w_access);
            end
            IBUS: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~(iREN & w_access);
            end
            default: ;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations adapt to ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    int          first_i;
    int          n_dwait;
    logic [31:0] addr5, addr7;

    initial begin
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        RST = 1'b0;

        // reset in the middle of a DBUS write
        dREN = 1; dWEN = 1; daddr = 32'h40; dstore = 32'h55; ramstate = BUSY;
        cyc();
        chk("midrst_pre_wen", ramWEN, 1);
        chk("midrst_pre_addr", ramaddr, 32'h40);
        #2 RST = 1'b1;
        #1;
        chk("midrst_wen", ramWEN, 0);
        chk("midrst_addr", ramaddr, 0);
        chk("midrst_iwait", iwait, 1);
        chk("midrst_dwait", dwait, 1);
        dREN = 0; dWEN = 0; daddr = 0; dstore = 0; ramstate = FREE;
        cyc();
        RST = 1'b0;
        #1;
        chk("postrst_ren", ramREN, 0);
        chk("postrst_wen", ramWEN, 0);

        // lone instruction fetch, ACCESS two cycles after grant
        iREN = 1; iaddr = 32'h100;
        #1 chk("if_c0_ren", ramREN, 0);
        cyc(); ramstate = BUSY;
        #1 chk("if_c1_addr", ramaddr, 32'h100);
        chk("if_c1_ren", ramREN, 1);
        chk("if_c1_iwait", iwait, 1);
        chk("if_c1_dwait", dwait, 1);
        cyc();
        #1 chk("if_c2_iwait", iwait, 1);
        cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #1 chk("if_c3_iwait", iwait, 0);
        chk("if_c3_iload", iload, 32'hDEADBEEF);
        chk("if_c3_dwait", dwait, 1);
        cyc(); iREN = 0; ramstate = FREE;
        #1 chk("if_c4_idle", ramREN, 0);

        // simultaneous requests: dcache first
        cyc(); iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h300;
        cyc(); ramstate = BUSY;
        #1 chk("sim_c1_addr", ramaddr, 32'h300);
        chk("sim_c1_dwait", dwait, 1);
        cyc(); ramstate = ACCESS; ramload = 32'h0000A5A5;
        #1 chk("sim_c2_dwait", dwait, 0);
        chk("sim_c2_dload", dload, 32'h0000A5A5);
        chk("sim_c2_iwait", iwait, 1);
        cyc(); dREN = 0; ramstate = FREE;
        #1 chk("sim_c3_idle", ramREN, 0);
        chk("sim_c3_iwait", iwait, 1);
        cyc(); ramstate = BUSY;
        #1 chk("sim_c4_addr", ramaddr, 32'h200);
        chk("sim_c4_iwait", iwait, 1);
        cyc(); ramstate = ACCESS;
        #1 chk("sim_c5_iwait", iwait, 0);
        cyc(); iREN = 0; ramstate = FREE;

        // write wins over read, ERROR holds the grant
        cyc(); dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
        for (int k = 1; k <= 3; k++) begin
            cyc(); ramstate = ERROR;
            #1 chk("err_wen", ramWEN, 1);
            chk("err_ren", ramREN, 0);
            chk("err_dwait", dwait, 1);
        end
        chk("err_store", ramstore, 32'h1234);
        cyc(); ramstate = ACCESS;
        #1 chk("err_acc_dwait", dwait, 0);
        chk("err_acc_wen", ramWEN, 1);
        cyc(); dREN = 0; dWEN = 0; ramstate = FREE;
        #1 chk("err_after_wen", ramWEN, 0);

        // dcache drops its request mid-grant: back to IDLE, no completion
        cyc(); dREN = 1; daddr = 32'h600;
        cyc(); ramstate = BUSY;
        #1 chk("drop_c1_ren", ramREN, 1);
        cyc(); dREN = 0; ramstate = ACCESS;
        #1 chk("drop_c2_dwait", dwait, 1);
        chk("drop_c2_ren", ramREN, 0);
        cyc(); ramstate = FREE; iREN = 1; iaddr = 32'h700;
        #1 chk("drop_c3_idle", ramaddr, 0);
        cyc(); ramstate = ACCESS;
        #1 chk("drop_c4_addr", ramaddr, 32'h700);
        chk("drop_c4_iwait", iwait, 0);
        cyc(); iREN = 0; ramstate = FREE;
        cyc();

        // sustained dcache traffic against a waiting instruction fetch, zero-wait RAM
        iREN = 1; iaddr = 32'h500; dREN = 1; daddr = 32'h400;
        first_i = -1; n_dwait = 0; addr5 = 0; addr7 = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            ramstate = (ramREN | ramWEN) ? ACCESS : FREE;
            #1;
            if (!iwait && first_i < 0) first_i = c;
            if (!dwait) n_dwait++;
            if (c == 5) addr5 = ramaddr;
            if (c == 7) addr7 = ramaddr;
            cyc();
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("starve_first_i", first_i, 5);
        chk("starve_c5_addr", addr5, 32'h500);
        chk("starve_c7_addr", addr7, 32'h400);
`else
        chk("starve_first_i", first_i, -1);
        chk("starve_c5_addr", addr5, 32'h400);
        chk("starve_c7_addr", addr7, 32'h400);
        chk("starve_dcount", n_dwait, 50);
`endif
        iREN = 0; dREN = 0; ramstate = FREE;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
